// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode map, instruction classes and sequencer states for the
// hardwired control unit that drives the 32-bit register-bus datapath.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'd0;
    localparam logic [4:0] OP_LDI  = 5'd1;
    localparam logic [4:0] OP_ST   = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_SHR  = 5'd7;
    localparam logic [4:0] OP_SHRA = 5'd8;
    localparam logic [4:0] OP_SHL  = 5'd9;
    localparam logic [4:0] OP_ROR  = 5'd10;
    localparam logic [4:0] OP_ROL  = 5'd11;
    localparam logic [4:0] OP_ADDI = 5'd12;
    localparam logic [4:0] OP_ANDI = 5'd13;
    localparam logic [4:0] OP_ORI  = 5'd14;
    localparam logic [4:0] OP_MUL  = 5'd15;
    localparam logic [4:0] OP_DIV  = 5'd16;
    localparam logic [4:0] OP_NEG  = 5'd17;
    localparam logic [4:0] OP_NOT  = 5'd18;
    localparam logic [4:0] OP_BR   = 5'd19;
    localparam logic [4:0] OP_JR   = 5'd20;
    localparam logic [4:0] OP_JAL  = 5'd21;
    localparam logic [4:0] OP_IN   = 5'd22;
    localparam logic [4:0] OP_OUT  = 5'd23;
    localparam logic [4:0] OP_MFHI = 5'd24;
    localparam logic [4:0] OP_MFLO = 5'd25;
    localparam logic [4:0] OP_NOP  = 5'd26;
    localparam logic [4:0] OP_HALT = 5'd27;

    localparam logic [4:0] ALU_ADD = OP_ADD;

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_ALU, C_IMM, C_LDI, C_LD, C_ST, C_MULDIV, C_UNARY, C_BR,
        C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
    } iclass_t;

endpackage

// File: rtl/control_unit_decode.sv
// Combinational opcode-to-class decoder; undefined opcodes fall into HALT.
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [4:0] i_op,
    output iclass_t    o_class
);

    always_comb begin
        o_class = C_HALT;
        case (i_op) inside
            OP_LD:             o_class = C_LD;
            OP_LDI:            o_class = C_LDI;
            OP_ST:             o_class = C_ST;
            [OP_ADD:OP_ROL]:   o_class = C_ALU;
            [OP_ADDI:OP_ORI]:  o_class = C_IMM;
            OP_MUL, OP_DIV:    o_class = C_MULDIV;
            OP_NEG, OP_NOT:    o_class = C_UNARY;
            OP_BR:             o_class = C_BR;
            OP_JR:             o_class = C_JR;
            OP_JAL:            o_class = C_JAL;
            OP_IN:             o_class = C_IN;
            OP_OUT:            o_class = C_OUT;
            OP_MFHI:           o_class = C_MFHI;
            OP_MFLO:           o_class = C_MFLO;
            OP_NOP:            o_class = C_NOP;
            default:           o_class = C_HALT;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Moore fetch/decode/execute sequencer; one state per clock, strobes decoded
// from the registered state and the instruction class latched at T2.
module control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int OP_W  = 5,
    parameter int ALU_W = 5
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [31:0]      IR,
    input  logic             CON,
    output logic             PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, CONin, OUTPORTin,
    output logic             PCout, MDRout, Yout, ZHIout, ZLOout, HIout, LOout, INPORTout, OUTPORTout, Cout,
    output logic             Gra, Grb, Grc, Rin, Rout, BAout,
    output logic             Read, Write, IncPC,
    output logic [ALU_W-1:0] alu_op,
    output logic             Run
);

    state_t          r_state;
    iclass_t         r_class;
    logic [OP_W-1:0] r_op;
    logic [OP_W-1:0] w_op;
    iclass_t         w_class;
    logic            w_unused_ir;

    assign w_op        = IR[31 -: OP_W];
    assign w_unused_ir = ^IR[31-OP_W:0];

    ctrl_decode u_decode (
        .i_op    (w_op),
        .o_class (w_class)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= S_RESET;
            r_class <= C_NOP;
            r_op    <= '0;
        end else begin
            case (r_state)
                S_RESET: r_state <= S_T0;
                S_T0:    r_state <= S_T1;
                S_T1:    r_state <= S_T2;
                S_T2: begin
                    r_op    <= w_op;
                    r_class <= w_class;
                    case (w_class)
                        C_NOP:   r_state <= S_T0;
                        C_HALT:  r_state <= S_HALT;
                        default: r_state <= S_T3;
                    endcase
                end
                S_T3: r_state <= (r_class inside {C_JR, C_IN, C_OUT, C_MFHI, C_MFLO}) ? S_T0 : S_T4;
                S_T4: r_state <= (r_class inside {C_UNARY, C_JAL}) ? S_T0 : S_T5;
                S_T5: r_state <= (r_class inside {C_ALU, C_IMM, C_LDI}) ? S_T0 : S_T6;
                S_T6: r_state <= (r_class inside {C_MULDIV, C_BR}) ? S_T0 : S_T7;
                S_T7: r_state <= S_T0;
                S_HALT: r_state <= S_HALT;
                default: r_state <= S_RESET;
            endcase
        end
    end

    always_comb begin
        {PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, CONin, OUTPORTin} = '0;
        {PCout, MDRout, Yout, ZHIout, ZLOout, HIout, LOout, INPORTout, OUTPORTout, Cout} = '0;
        {Gra, Grb, Grc, Rin, Rout, BAout, Read, Write, IncPC} = '0;
        alu_op = '0;
        Run    = (r_state != S_RESET) && (r_state != S_HALT);
        case (r_state)
            S_T0: begin PCout = 1'b1; MARin = 1'b1; end
            S_T1: begin Read = 1'b1; MDRin = 1'b1; PCin = 1'b1; IncPC = 1'b1; end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_T3: begin
                case (r_class)
                    C_ALU, C_IMM:        begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    C_LDI, C_LD, C_ST:   begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                    C_MULDIV:            begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    C_UNARY:             begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = ALU_W'(r_op); end
                    C_BR:                begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                    C_JR:                begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                    C_JAL:               begin PCout = 1'b1; Grb = 1'b1; Rin = 1'b1; end
                    C_IN:                begin INPORTout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    C_OUT:               begin Gra = 1'b1; Rout = 1'b1; OUTPORTin = 1'b1; end
                    C_MFHI:              begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    C_MFLO:              begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    default: ;
                endcase
            end
            S_T4: begin
                case (r_class)
                    C_ALU:               begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = ALU_W'(r_op); end
                    C_IMM:               begin Cout = 1'b1; Zin = 1'b1; alu_op = ALU_W'(r_op); end
                    C_LDI, C_LD, C_ST:   begin Cout = 1'b1; Zin = 1'b1; alu_op = ALU_W'(ALU_ADD); end
                    C_MULDIV:            begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = ALU_W'(r_op); end
                    C_UNARY:             begin ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    C_BR:                begin PCout = 1'b1; Yin = 1'b1; end
                    C_JAL:               begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                    default: ;
                endcase
            end
            S_T5: begin
                case (r_class)
                    C_ALU, C_IMM, C_LDI: begin ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    C_LD, C_ST:          begin ZLOout = 1'b1; MARin = 1'b1; end
                    C_MULDIV:            begin ZLOout = 1'b1; LOin = 1'b1; end
                    C_BR:                begin Cout = 1'b1; Zin = 1'b1; alu_op = ALU_W'(ALU_ADD); end
                    default: ;
                endcase
            end
            S_T6: begin
                case (r_class)
                    C_LD:                begin Read = 1'b1; MDRin = 1'b1; end
                    // Read stays low so the MDR mux takes the bus value to be stored.
                    C_ST:                begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                    C_MULDIV:            begin ZHIout = 1'b1; HIin = 1'b1; end
                    C_BR:                begin ZLOout = CON; PCin = CON; end
                    default: ;
                endcase
            end
            S_T7: begin
                case (r_class)
                    C_LD:                begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    C_ST:                Write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench: a per-instruction cycle-sequence model feeds an expectation
// queue that is checked against the DUT strobes every cycle.
module tb_control_unit;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] IR = '0;
    logic        CON = 1'b0;
    logic PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, CONin, OUTPORTin;
    logic PCout, MDRout, Yout, ZHIout, ZLOout, HIout, LOout, INPORTout, OUTPORTout, Cout;
    logic Gra, Grb, Grc, Rin, Rout, BAout, Read, Write, IncPC, Run;
    logic [4:0] alu_op;

    control_unit dut (
        .Clock(Clock), .Reset(Reset), .IR(IR), .CON(CON),
        .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .Zin(Zin),
        .HIin(HIin), .LOin(LOin), .CONin(CONin), .OUTPORTin(OUTPORTin),
        .PCout(PCout), .MDRout(MDRout), .Yout(Yout), .ZHIout(ZHIout), .ZLOout(ZLOout),
        .HIout(HIout), .LOout(LOout), .INPORTout(INPORTout), .OUTPORTout(OUTPORTout), .Cout(Cout),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .Read(Read), .Write(Write), .IncPC(IncPC), .alu_op(alu_op), .Run(Run)
    );

    always #5 Clock = ~Clock;

    localparam logic [34:0] M_PCIN   = 35'd1 << 0,  M_IRIN   = 35'd1 << 1,  M_MARIN  = 35'd1 << 2;
    localparam logic [34:0] M_MDRIN  = 35'd1 << 3,  M_YIN    = 35'd1 << 4,  M_ZIN    = 35'd1 << 5;
    localparam logic [34:0] M_HIIN   = 35'd1 << 6,  M_LOIN   = 35'd1 << 7,  M_CONIN  = 35'd1 << 8;
    localparam logic [34:0] M_OPIN   = 35'd1 << 9,  M_PCOUT  = 35'd1 << 10, M_MDROUT = 35'd1 << 11;
    localparam logic [34:0] M_ZHIOUT = 35'd1 << 13, M_ZLOOUT = 35'd1 << 14;
    localparam logic [34:0] M_HIOUT  = 35'd1 << 15, M_LOOUT  = 35'd1 << 16, M_IPOUT  = 35'd1 << 17;
    localparam logic [34:0] M_COUT   = 35'd1 << 19, M_GRA    = 35'd1 << 20;
    localparam logic [34:0] M_GRB    = 35'd1 << 21, M_GRC    = 35'd1 << 22, M_RIN    = 35'd1 << 23;
    localparam logic [34:0] M_ROUT   = 35'd1 << 24, M_BAOUT  = 35'd1 << 25, M_READ   = 35'd1 << 26;
    localparam logic [34:0] M_WRITE  = 35'd1 << 27, M_INCPC  = 35'd1 << 28, M_RUN    = 35'd1 << 29;

    logic [34:0] dv;
    assign dv = {alu_op, Run, IncPC, Write, Read, BAout, Rout, Rin, Grc, Grb, Gra, Cout,
                 OUTPORTout, INPORTout, LOout, HIout, ZLOout, ZHIout, Yout, MDRout, PCout,
                 OUTPORTin, CONin, LOin, HIin, Zin, Yin, MDRin, MARin, IRin, PCin};

    logic [34:0] exp_q[$];
    logic [34:0] e;
    int checks = 0;
    int failures = 0;
    int step = 0;
    int hl_pulse = 0;
    logic abort_win = 1'b0;
    logic [4:0] cur_op = '0;

    function automatic logic [34:0] aluf(input logic [4:0] op);
        return 35'(op) << 30;
    endfunction

    // Expected strobe sequence of one whole instruction, one entry per cycle.
    task automatic push_instr(input logic [4:0] op, input logic con);
        exp_q.push_back(M_RUN | M_PCOUT | M_MARIN);
        exp_q.push_back(M_RUN | M_READ | M_MDRIN | M_PCIN | M_INCPC);
        exp_q.push_back(M_RUN | M_MDROUT | M_IRIN);
        if (op >= 3 && op <= 11) begin
            exp_q.push_back(M_RUN | M_GRB | M_ROUT | M_YIN);
            exp_q.push_back(M_RUN | M_GRC | M_ROUT | M_ZIN | aluf(op));
            exp_q.push_back(M_RUN | M_ZLOOUT | M_GRA | M_RIN);
        end else if (op >= 12 && op <= 14) begin
            exp_q.push_back(M_RUN | M_GRB | M_ROUT | M_YIN);
            exp_q.push_back(M_RUN | M_COUT | M_ZIN | aluf(op));
            exp_q.push_back(M_RUN | M_ZLOOUT | M_GRA | M_RIN);
        end else if (op <= 2) begin
            exp_q.push_back(M_RUN | M_GRB | M_BAOUT | M_YIN);
            exp_q.push_back(M_RUN | M_COUT | M_ZIN | aluf(5'd3));
            if (op == 1) exp_q.push_back(M_RUN | M_ZLOOUT | M_GRA | M_RIN);
            else begin
                exp_q.push_back(M_RUN | M_ZLOOUT | M_MARIN);
                if (op == 0) begin
                    exp_q.push_back(M_RUN | M_READ | M_MDRIN);
                    exp_q.push_back(M_RUN | M_MDROUT | M_GRA | M_RIN);
                end else begin
                    exp_q.push_back(M_RUN | M_GRA | M_ROUT | M_MDRIN);
                    exp_q.push_back(M_RUN | M_WRITE);
                end
            end
        end else if (op == 15 || op == 16) begin
            exp_q.push_back(M_RUN | M_GRA | M_ROUT | M_YIN);
            exp_q.push_back(M_RUN | M_GRB | M_ROUT | M_ZIN | aluf(op));
            exp_q.push_back(M_RUN | M_ZLOOUT | M_LOIN);
            exp_q.push_back(M_RUN | M_ZHIOUT | M_HIIN);
        end else if (op == 17 || op == 18) begin
            exp_q.push_back(M_RUN | M_GRB | M_ROUT | M_ZIN | aluf(op));
            exp_q.push_back(M_RUN | M_ZLOOUT | M_GRA | M_RIN);
        end else if (op == 19) begin
            exp_q.push_back(M_RUN | M_GRA | M_ROUT | M_CONIN);
            exp_q.push_back(M_RUN | M_PCOUT | M_YIN);
            exp_q.push_back(M_RUN | M_COUT | M_ZIN | aluf(5'd3));
            exp_q.push_back(con ? (M_RUN | M_ZLOOUT | M_PCIN) : M_RUN);
        end else if (op == 20) exp_q.push_back(M_RUN | M_GRA | M_ROUT | M_PCIN);
        else if (op == 21) begin
            exp_q.push_back(M_RUN | M_PCOUT | M_GRB | M_RIN);
            exp_q.push_back(M_RUN | M_GRA | M_ROUT | M_PCIN);
        end
        else if (op == 22) exp_q.push_back(M_RUN | M_IPOUT | M_GRA | M_RIN);
        else if (op == 23) exp_q.push_back(M_RUN | M_GRA | M_ROUT | M_OPIN);
        else if (op == 24) exp_q.push_back(M_RUN | M_HIOUT | M_GRA | M_RIN);
        else if (op == 25) exp_q.push_back(M_RUN | M_LOOUT | M_GRA | M_RIN);
        else if (op >= 27) for (int i = 0; i < 22; i++) exp_q.push_back('0);
    endtask

    always @(negedge Clock) begin
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            step++;
            checks++;
            if (dv !== e) begin
                failures++;
                $display("FAIL seq step=%0d op=%0d got=%h exp=%h", step, cur_op, dv, e);
            end
        end
    end

    always @(posedge HIin or posedge LOin) if (abort_win) hl_pulse++;

    task automatic check_lit(input string name, input logic [34:0] got, input logic [34:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, expv);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge Clock);
            n++;
        end
        if (n >= 300) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout got=%0d exp=0", exp_q.size());
            exp_q.delete();
        end
        #1;
    endtask

    task automatic load(input logic [4:0] op, input logic con);
        cur_op = op;
        IR = {op, 27'($urandom)};
        CON = con;
        push_instr(op, con);
    endtask

    task automatic run(input logic [4:0] op, input logic con);
        wait_drain();
        load(op, con);
    endtask

    task automatic do_reset(input string name, input logic [4:0] op);
        wait_drain();
        Reset = 1'b1;
        #1 check_lit(name, dv, '0);
        @(posedge Clock);
        #1 Reset = 1'b0;
        exp_q.push_back('0);
        load(op, 1'b0);
    endtask

    initial begin
        #3 check_lit("reset_state", dv, '0);
        @(posedge Clock);
        @(posedge Clock);
        #1 Reset = 1'b0;
        exp_q.push_back('0);
        load(5'd3, 1'b0);
        run(5'd0, 1'b0);
        run(5'd2, 1'b0);
        run(5'd12, 1'b0);
        run(5'd1, 1'b0);
        run(5'd19, 1'b1);
        run(5'd19, 1'b0);
        run(5'd20, 1'b0);
        run(5'd21, 1'b0);
        run(5'd16, 1'b0);
        run(5'd17, 1'b0);
        run(5'd22, 1'b0);
        run(5'd23, 1'b0);
        run(5'd24, 1'b0);
        run(5'd25, 1'b0);
        run(5'd26, 1'b0);
        run(5'd10, 1'b0);
        run(5'd15, 1'b0);
        run(5'd14, 1'b0);

        // Abort a mul in T4 with an asynchronous reset.
        run(5'd15, 1'b0);
        exp_q = exp_q[0:3];
        abort_win = 1'b1;
        wait_drain();
        check_lit("mul_t4", dv, M_RUN | M_GRB | M_ROUT | M_ZIN | (35'd15 << 30));
        Reset = 1'b1;
        #1 check_lit("abort_zero", dv, '0);
        exp_q.push_back('0);
        exp_q.push_back('0);
        @(posedge Clock);
        @(posedge Clock);
        #1 Reset = 1'b0;
        exp_q.push_back('0);
        load(5'd4, 1'b0);
        wait_drain();
        abort_win = 1'b0;
        checks++;
        if (hl_pulse != 0) begin
            failures++;
            $display("FAIL abort_hilo got=%0d exp=0", hl_pulse);
        end
        load(5'd27, 1'b0);
        wait_drain();
        check_lit("halt_hold", dv, '0);
        do_reset("halt_reset", 5'd31);
        wait_drain();
        check_lit("undef_hold", dv, '0);
        do_reset("undef_reset", 5'd3);
        wait_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
